// File: rtl/udp_delay_pkg.sv
// udp_delay_pkg: shared state type, width derivation and latency clamp for udp_delay_line
package udp_delay_pkg;
  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;
  function automatic int lat_width(input int max_depth);
    return $clog2(max_depth + 1);
  endfunction
  function automatic int addr_width(input int max_depth);
    return max_depth < 2 ? 1 : $clog2(max_depth);
  endfunction
  function automatic int clamp_lat(input int lat, input int max_depth);
    return lat < 1 ? 1 : (lat > max_depth ? max_depth : lat);
  endfunction
endpackage

// File: rtl/udp_delay_ram.sv
// udp_delay_ram: simple dual-port storage, one write port and one asynchronous read port
module udp_delay_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/udp_delay_line.sv
// udp_delay_line: runtime-programmable delay line with fill-tracking valid.
// Define UDP_DELAY_OUT_REG_EN to add one output register stage (latency L+1).
module udp_delay_line
  import udp_delay_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DEPTH = 16,
  parameter int DEFAULT_LAT = 8,
  parameter int LAT_W = lat_width(MAX_DEPTH),
  parameter int AW = addr_width(MAX_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  lat_load,
  input  logic [LAT_W-1:0]      lat_in,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic [LAT_W-1:0]      lat_cur,
  output logic                  filling
);
  logic [AW-1:0] wp, rd;
  logic [AW:0] rsum;
  logic [LAT_W-1:0] cnt;
  logic [DATA_WIDTH-1:0] rdata, dly;
  logic dly_valid, restart;
  state_t state;
  assign restart = lat_load | flush;
  // read index wp-(L-1) modulo MAX_DEPTH, which need not be a power of two
  assign rsum = {1'b0, wp} + (AW+1)'(MAX_DEPTH) - (AW+1)'(lat_cur - 1'b1);
  assign rd = rsum >= (AW+1)'(MAX_DEPTH) ? AW'(rsum - (AW+1)'(MAX_DEPTH)) : AW'(rsum);
  assign filling = state == FILL;
  udp_delay_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MAX_DEPTH), .AW(AW)) u_ram (
    .clk(clk), .we(ce), .waddr(wp), .wdata(din), .raddr(rd), .rdata(rdata)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      dly <= '0;
    end else if (ce) begin
      wp <= wp == AW'(MAX_DEPTH - 1) ? '0 : wp + 1'b1;
      dly <= lat_cur == LAT_W'(1) ? din : rdata;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lat_cur <= LAT_W'(DEFAULT_LAT);
      cnt <= '0;
      state <= FILL;
      dly_valid <= 1'b0;
    end else begin
      if (lat_load) lat_cur <= LAT_W'(clamp_lat(int'(lat_in), MAX_DEPTH));
      if (restart) begin
        cnt <= '0;
        state <= FILL;
        dly_valid <= 1'b0;
      end else if (ce && state == FILL) begin
        cnt <= cnt + 1'b1;
        if (cnt + 1'b1 == lat_cur) begin
          state <= RUN;
          dly_valid <= 1'b1;
        end
      end
    end
`ifdef UDP_DELAY_OUT_REG_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dout <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (ce) dout <= dly;
      dout_valid <= restart ? 1'b0 : (ce ? dly_valid : dout_valid);
    end
`else
  assign dout = dly;
  assign dout_valid = dly_valid;
`endif
endmodule

// File: tb/tb_udp_delay_line.sv
// tb_udp_delay_line: randomized directed bench against a sample-history reference model
module tb_udp_delay_line;
  localparam int DW = 8;
  localparam int MD = 16;
  localparam int LW = 5;
`ifdef UDP_DELAY_OUT_REG_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif
  logic clk = 1'b0, rst = 1'b1, ce = 1'b0, lat_load = 1'b0, flush = 1'b0;
  logic [DW-1:0] din = '0, dout;
  logic [LW-1:0] lat_in = '0, lat_cur;
  logic dout_valid, filling;
  int total = 0, bad = 0;
  logic [DW-1:0] hist[$];
  int since = 0, m_lat = 8;
  udp_delay_line #(.DATA_WIDTH(DW), .MAX_DEPTH(MD), .DEFAULT_LAT(8)) dut (
    .clk(clk), .rst(rst), .ce(ce), .din(din), .lat_load(lat_load), .lat_in(lat_in),
    .flush(flush), .dout(dout), .dout_valid(dout_valid), .lat_cur(lat_cur), .filling(filling)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ":lat_cur"}, 32'(lat_cur), 32'(m_lat));
    chk({tag, ":valid"}, 32'(dout_valid), 32'(since >= m_lat + XL));
    chk({tag, ":filling"}, 32'(filling), 32'(since < m_lat));
    if (since >= m_lat + XL) chk({tag, ":dout"}, 32'(dout), 32'(hist[hist.size() - m_lat - XL]));
  endtask
  task automatic tick(input string tag, input logic c, input logic ld, input int li, input logic fl);
    ce = c;
    lat_load = ld;
    lat_in = LW'(li);
    flush = fl;
    din = DW'($urandom);
    @(posedge clk);
    #1;
    if (c) hist.push_back(din);
    if (ld) m_lat = li < 1 ? 1 : (li > MD ? MD : li);
    if (ld || fl) since = 0;
    else if (c) since++;
    ce = 1'b0;
    lat_load = 1'b0;
    flush = 1'b0;
    check_all(tag);
  endtask
  task automatic model_reset();
    hist.delete();
    since = 0;
    m_lat = 8;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst:dout", 32'(dout), 0);
    chk("rst:valid", 32'(dout_valid), 0);
    chk("rst:lat_cur", 32'(lat_cur), 8);
    chk("rst:filling", 32'(filling), 1);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) tick("l8", 1'b1, 1'b0, 0, 1'b0);
    tick("ld4", 1'b1, 1'b1, 4, 1'b0);
    for (int i = 0; i < 30; i++) tick("ce_tgl", 1'($urandom_range(1)), 1'b0, 0, 1'b0);
    tick("ld3", 1'b1, 1'b1, 3, 1'b0);
    for (int i = 0; i < 10; i++) tick("l3", 1'b1, 1'b0, 0, 1'b0);
    tick("ld0", 1'b0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 10; i++) tick("l1", 1'b1, 1'b0, 0, 1'b0);
    tick("ldbig", 1'b1, 1'b1, MD + 5, 1'b0);
    for (int i = 0; i < 40; i++) tick("l16", 1'b1, 1'b0, 0, 1'b0);
    tick("ld5fl", 1'b1, 1'b1, 5, 1'b1);
    for (int i = 0; i < 8; i++) tick("l5", 1'b1, 1'b0, 0, 1'b0);
    tick("ld4b", 1'b1, 1'b1, 4, 1'b0);
    for (int i = 0; i < 2; i++) tick("pre_fl", 1'b1, 1'b0, 0, 1'b0);
    tick("fl", 1'b0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 6; i++) tick("post_fl", 1'b1, 1'b0, 0, 1'b0);
    tick("ld_same", 1'b1, 1'b1, 4, 1'b0);
    for (int i = 0; i < 6; i++) tick("post_same", 1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 120; i++)
      tick("rand", 1'($urandom_range(3) != 0), 1'($urandom_range(14) == 0),
           int'($urandom_range(MD + 4)), 1'($urandom_range(11) == 0));
    tick("ld2", 1'b1, 1'b1, 2, 1'b0);
    for (int i = 0; i < 6; i++) tick("pre_rst", 1'b1, 1'b0, 0, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("arst:dout", 32'(dout), 0);
    chk("arst:valid", 32'(dout_valid), 0);
    chk("arst:lat_cur", 32'(lat_cur), 8);
    chk("arst:filling", 32'(filling), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 14; i++) tick("post_rst", 1'b1, 1'b0, 0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/udp_delay_line.md
Name: udp_delay_line

Overview:
- Runtime-programmable delay line: delays DATA_WIDTH-bit samples by L clock-enabled cycles, L in 1..MAX_DEPTH.
- Successor to the fixed-latency UDP shift register. Adds clock enable, runtime latency reload, flush, and a fill-tracking output valid.
- Sits in the UDP/Ethernet datapath to align payload bytes with header/checksum pipelines of variable length.

Parameters:
- DATA_WIDTH, 8, sample width (1..256)
- MAX_DEPTH, 16, largest programmable latency (1..1024)
- DEFAULT_LAT, 8, latency after reset (1..MAX_DEPTH)
- LAT_W, derived = clog2(MAX_DEPTH+1), latency field width
- AW, derived = max(1, clog2(MAX_DEPTH)), storage address width

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ce  in  1  clock enable; the line advances only when ce=1
- din  in  DATA_WIDTH  input sample, captured when ce=1
- lat_load  in  1  single-cycle pulse; loads lat_in as the new latency
- lat_in  in  LAT_W  requested latency
- flush  in  1  restarts fill tracking; stored data untouched
- dout  out  DATA_WIDTH  delayed sample
- dout_valid  out  1  dout carries data captured since the last restart
- lat_cur  out  LAT_W  active latency
- filling  out  1  high while in state FILL

Interface: one clock, clk. Reset rst is asynchronous, active-high.

Behaviour:
- Reset (async assert): dout=0, dout_valid=0, lat_cur=DEFAULT_LAT, write pointer=0, fill count=0, state=FILL, filling=1. Storage contents are undefined and are masked by dout_valid.
- Latency definition:
  - Sample S is captured at the enabled edge E0.
  - S appears on dout immediately after the L-th enabled edge counting E0.
  - L=1: dout is a registered copy of din.
- Idle cycles: ce=0 holds every register, including dout and dout_valid.
- Storage: circular buffer of MAX_DEPTH entries. The write pointer increments on each enabled edge and wraps MAX_DEPTH-1 -> 0. The read index is (wp - (L-1)) mod MAX_DEPTH and must be correct across the wrap.
- lat_load:
  - lat_in=0 is clamped to 1; lat_in>MAX_DEPTH is clamped to MAX_DEPTH.
  - lat_cur updates on the next edge, regardless of ce.
  - The load restarts fill: count=0, state=FILL, dout_valid=0 on that edge.
- flush: same restart as lat_load, but lat_cur is unchanged. It acts regardless of ce.
- lat_load and flush together: the load wins; one restart occurs.
- FSM:
  - FILL: the count increments on each enabled edge. On the enabled edge where count+1 == lat_cur, go to RUN and set dout_valid=1 on that same edge.
  - RUN: dout_valid stays 1 until the next restart.
  - L=1: the first enabled edge after a restart goes directly to RUN.
- Restart during FILL or RUN: takes effect immediately; any partial fill is discarded.
- Loading a latency equal to lat_cur still restarts the fill.
- Data path is not cleared by a restart. dout keeps updating from the buffer but is flagged invalid.
- Reset asserted mid-operation: immediate return to reset values. On release, normal operation resumes from the first ce.

Optional Feature:
- UDP_DELAY_OUT_REG_EN defined:
  - Adds one extra output register on dout and dout_valid.
  - Total latency becomes L+1 enabled cycles; the extra stage also advances only on ce.
  - A restart clears the registered dout_valid on the same edge.
- Undefined: latency is exactly L, as above.

Decomposition:
- Package udp_delay_pkg holds:
  - state enum {FILL, RUN}
  - LAT_W/AW derivation function
  - latency clamp function (lat_in -> 1..MAX_DEPTH)
- Sub-module udp_delay_ram: simple dual-port memory with 1 write and 1 asynchronous/registered read, parameterised DATA_WIDTH and depth. It is chosen so synthesis maps to distributed RAM.
- Pointer/FSM logic lives in the top module.

Test Plan:
- Reset latency, continuous ce=1, din=0,1,2,...: dout_valid rises after the 8th enabled edge with dout=0; thereafter dout = din-8 on every cycle.
- ce toggled 1,0,1,0 with L=4, din incrementing only on enabled cycles: dout changes only on enabled edges and lags by exactly 4 enabled samples; held values are stable while ce=0.
- lat_load with lat_in=3 during RUN: next cycle lat_cur=3 and dout_valid=0; valid returns after 3 enabled edges with dout = sample captured 3 enabled edges earlier.
- lat_in=0 -> lat_cur=1 (dout=previous din); lat_in=MAX_DEPTH+5 -> lat_cur=16. Run 40 samples to cross the pointer wrap twice; no mismatch.
- flush and lat_load (lat_in=5) on the same cycle, and flush at fill count 2 of L=4: one restart, lat_cur=5, valid after 5 enabled edges. The flushed fill restarts from 0 and needs 4 more enabled edges.
- With UDP_DELAY_OUT_REG_EN, L=4: first valid appears after 5 enabled edges and dout = din-5. Asserting async rst mid-RUN drops dout_valid and dout to 0 without waiting for a clk edge.
